// File: rtl/seq_divider_pkg.sv
// Shared types for the execute-stage iterative divider.
// Imported by the divider and by the execute stage.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    typedef struct packed {
        logic signed_;
        logic word;
    } div_op_t;

    localparam int MAX_WIDTH = 128;
    localparam logic [MAX_WIDTH-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/seq_divider_step.sv
// One restoring division iteration, purely combinational.
// Kept standalone so a higher-radix step can replace it.
module div_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    assign shifted  = {rem, quo[WIDTH-1]};
    // The difference is only kept when it is below the divisor,
    // so the carry bit above WIDTH is never needed.
    assign diff     = shifted[WIDTH-1:0] - divisor;
    assign fits     = shifted >= {1'b0, divisor};
    assign rem_next = fits ? diff : shifted[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per cycle.
// Handles signed, unsigned and RV64 word forms.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter bit WORD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_signed,
    input  logic             op_word,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int H  = WIDTH / 2;
    localparam int CW = $clog2(WIDTH + 1);

    // Narrow to the effective width, then extend back to WIDTH.
    function automatic logic [WIDTH-1:0] fit(
        input logic [WIDTH-1:0] x,
        input logic             w,
        input logic             s
    );
        if (w)
            return s ? {{H{x[H-1]}}, x[H-1:0]}
                     : {{H{1'b0}}, x[H-1:0]};
        return x;
    endfunction

    div_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic             word_r;
    logic             neg_q;
    logic             neg_r;

    div_op_t          op;
    logic [WIDTH-1:0] ea;
    logic [WIDTH-1:0] eb;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] min_neg;
    logic             b_zero;
    logic             ovf;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] fix_quo;
    logic [WIDTH-1:0] fix_rem;

    assign op.signed_ = op_signed;
    assign op.word    = WORD_EN && op_word;

    assign ea    = fit(a, op.word, op.signed_);
    assign eb    = fit(b, op.word, op.signed_);
    assign sa    = op.signed_ & ea[WIDTH-1];
    assign sb    = op.signed_ & eb[WIDTH-1];
    assign mag_a = sa ? -ea : ea;
    assign mag_b = sb ? -eb : eb;

    // Most-negative value of the effective width, extended.
    assign min_neg = op.word
        ? {{(H+1){1'b1}}, {(H-1){1'b0}}}
        : {1'b1, {(WIDTH-1){1'b0}}};

    assign b_zero = (eb == '0);
    assign ovf    = op.signed_ && (eb == '1) && (ea == min_neg);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvs),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    assign fix_quo = neg_q ? -quo : quo;
    assign fix_rem = neg_r ? -rem : rem;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign quotient  = quo;
    assign remainder = rem;

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            quo    <= '0;
            rem    <= '0;
            dvs    <= '0;
            word_r <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && !flush) begin
                        word_r <= op.word;
                        if (b_zero) begin
                            quo   <= DIV_ZERO_Q[WIDTH-1:0];
                            rem   <= fit(ea, op.word, 1'b1);
                            state <= DONE;
                        end else if (ovf) begin
                            quo   <= ea;
                            rem   <= '0;
                            state <= DONE;
                        end else begin
                            // Dividend is left-aligned in quo so the
                            // step always shifts out of the top bit.
                            quo   <= op.word ? (mag_a << H) : mag_a;
                            rem   <= '0;
                            dvs   <= mag_b;
                            neg_q <= sa ^ sb;
                            neg_r <= sa;
                            cnt   <= op.word ? CW'(H) : CW'(WIDTH);
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        quo <= step_quo;
                        rem <= step_rem;
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1))
                            state <= FIX;
                    end
                end
                FIX: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        quo   <= fit(fix_quo, word_r, 1'b1);
                        rem   <= fit(fix_rem, word_r, 1'b1);
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (flush || out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
